// File: rtl/dmi_handler.sv
// DMI request handler: one register-bank access per DTM request, one response per request,
// with a sticky busy-error flag that only dmi_reset or rst_n clears.
//
// state  | meaning
// IDLE   | ready for a request; nops go straight to RESP
// ACCESS | one-cycle bank access using the latched request
// RESP   | response held until the DTM accepts it
module dmi_handler #(
  parameter int AddrWidth = 7,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [1:0]           resp_op,
  output logic [DataWidth-1:0] resp_data,
  input  logic                 dmi_reset,
  output logic [AddrWidth-1:0] reg_addr,
  output logic [DataWidth-1:0] reg_wdata,
  output logic                 reg_write,
  output logic                 reg_read,
  input  logic [DataWidth-1:0] reg_rdata,
  input  logic                 reg_hit,
  input  logic                 reg_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_WRITE    = 2'd2;
  localparam logic [1:0] ST_SUCCESS  = 2'd0;
  localparam logic [1:0] ST_FAILED   = 2'd2;
  localparam logic [1:0] ST_BUSY     = 2'd3;

  state_t               state_q, state_d;
  logic [1:0]           op_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [1:0]           resp_op_q;
  logic [DataWidth-1:0] resp_data_q;
  logic                 sticky_busy_q;

  logic req_is_rw;
  logic busy_result;
  logic access_ok;

  assign req_is_rw   = (req_op == OP_READ) || (req_op == OP_WRITE);
  assign busy_result = sticky_busy_q || reg_busy;
  assign access_ok   = reg_hit && !busy_result;

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign resp_op   = resp_op_q;
  assign resp_data = resp_data_q;

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    reg_write  = 1'b0;
    reg_read   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_is_rw ? ACCESS : RESP;
      end
      ACCESS: begin
        reg_write = (op_q == OP_WRITE) && access_ok;
        reg_read  = (op_q == OP_READ) && access_ok;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= 2'd0;
      addr_q        <= '0;
      wdata_q       <= '0;
      resp_op_q     <= ST_SUCCESS;
      resp_data_q   <= '0;
      sticky_busy_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_data;
        if (!req_is_rw) begin
          resp_op_q   <= ST_SUCCESS;
          resp_data_q <= '0;
        end
      end

      if (state_q == ACCESS) begin
        if (busy_result)   resp_op_q <= ST_BUSY;
        else if (!reg_hit) resp_op_q <= ST_FAILED;
        else               resp_op_q <= ST_SUCCESS;
        resp_data_q <= ((op_q == OP_READ) && access_ok) ? reg_rdata : '0;
      end

      // A fresh busy error outranks a dmi_reset arriving in the same cycle.
      if (state_q == ACCESS && busy_result) sticky_busy_q <= 1'b1;
      else if (dmi_reset)                   sticky_busy_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmi_handler.sv
// Self-checking bench for dmi_handler: behavioural bank and transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_dmi_handler;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid, resp_ready;
  logic [1:0]    resp_op;
  logic [DW-1:0] resp_data;
  logic          dmi_reset;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_write, reg_read;
  logic [DW-1:0] reg_rdata;
  logic          reg_hit, reg_busy;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmi_handler #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op), .resp_data(resp_data),
    .dmi_reset(dmi_reset),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write), .reg_read(reg_read),
    .reg_rdata(reg_rdata), .reg_hit(reg_hit), .reg_busy(reg_busy)
  );

  // Behavioural register bank: addresses below 0x60 are implemented.
  logic [DW-1:0] bank [0:127];
  assign reg_hit   = (reg_addr < 7'h60);
  assign reg_rdata = bank[reg_addr];
  always @(posedge clk) if (reg_write) bank[reg_addr] <= reg_wdata;

  int            wr_cnt = 0, rd_cnt = 0;
  logic [DW-1:0] last_wdata;
  logic [AW-1:0] last_waddr;
  always @(posedge clk) begin
    if (reg_write) begin wr_cnt++; last_wdata = reg_wdata; last_waddr = reg_addr; end
    if (reg_read) rd_cnt++;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:127];
  bit            ref_sticky;

  task automatic pred(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input bit busy, input bit clr_at_accept,
                      output logic [1:0] e_op, output logic [DW-1:0] e_data,
                      output int e_wr, output int e_rd);
    if (clr_at_accept) ref_sticky = 0;
    e_op = 2'd0; e_data = '0; e_wr = 0; e_rd = 0;
    if (op == 2'd1 || op == 2'd2) begin
      if (ref_sticky || busy) begin
        e_op = 2'd3;
        ref_sticky = 1;
      end else if (addr >= 7'h60) begin
        e_op = 2'd2;
      end else if (op == 2'd2) begin
        e_wr = 1;
        ref_mem[addr] = data;
      end else begin
        e_rd = 1;
        e_data = ref_mem[addr];
      end
    end
  endtask

  // Drives one request from IDLE through its response; reports what was seen.
  task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input bit busy, input bit clr_at_accept, input bit clr_in_access,
                         input int resp_wait,
                         output logic [1:0] r_op, output logic [DW-1:0] r_data,
                         output int nwr, output int nrd, output bit timing_ok);
    int w0, r0;
    bit rw;
    rw = (op == 2'd1 || op == 2'd2);
    @(negedge clk);
    timing_ok = req_ready;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    reg_busy = busy; dmi_reset = clr_at_accept;
    w0 = wr_cnt; r0 = rd_cnt;
    @(negedge clk);
    req_valid = 1'b0; dmi_reset = 1'b0;
    if (rw) begin
      if (resp_valid || req_ready) timing_ok = 0;
      dmi_reset = clr_in_access;
      @(negedge clk);
      dmi_reset = 1'b0;
    end
    reg_busy = 1'b0;
    if (!resp_valid) timing_ok = 0;
    r_op = resp_op; r_data = resp_data;
    repeat (resp_wait) begin
      @(negedge clk);
      if (!resp_valid || resp_op !== r_op || resp_data !== r_data || req_ready) timing_ok = 0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    if (resp_valid || !req_ready) timing_ok = 0;
    nwr = wr_cnt - w0;
    nrd = rd_cnt - r0;
  endtask

  logic [1:0]    g_op, e_op;
  logic [DW-1:0] g_data, e_data;
  int            g_wr, g_rd, e_wr, e_rd;
  bit            g_t;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, resp_op, resp_data, reg_write, reg_read, reg_addr, reg_wdata} !==
        {1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b op=%0d data=%h wr=%b rd=%b addr=%h wd=%h",
               req_ready, resp_valid, resp_op, resp_data, reg_write, reg_read, reg_addr, reg_wdata);
    end
    rst_n = 1'b1;
    ref_sticky = 0;
  endtask

  task automatic test_write_read();
    pred(2'd2, 7'h10, 32'hDEADBEEF, 0, 0, e_op, e_data, e_wr, e_rd);
    run_txn(2'd2, 7'h10, 32'hDEADBEEF, 0, 0, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
    vectors++;
    if ({g_op, g_data, g_t} !== {e_op, e_data, 1'b1} || g_wr != 1 || g_rd != 0 || last_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_10: got op=%0d data=%h wr=%0d rd=%0d wdata=%h timing=%b, expected op=%0d data=%h wr=1 rd=0 wdata=deadbeef",
               g_op, g_data, g_wr, g_rd, last_wdata, g_t, e_op, e_data);
    end
    pred(2'd1, 7'h10, 32'h0, 0, 0, e_op, e_data, e_wr, e_rd);
    run_txn(2'd1, 7'h10, 32'h0, 0, 0, 0, 1, g_op, g_data, g_wr, g_rd, g_t);
    vectors++;
    if ({g_op, g_data, g_t} !== {2'd0, 32'hDEADBEEF, 1'b1} || g_wr != 0 || g_rd != 1) begin
      miscompares++;
      $display("FAIL read_10: got op=%0d data=%h wr=%0d rd=%0d timing=%b, expected op=0 data=deadbeef wr=0 rd=1",
               g_op, g_data, g_wr, g_rd, g_t);
    end
  endtask

  task automatic test_unimplemented();
    for (int k = 1; k <= 2; k++) begin
      pred(2'(k), 7'h7F, 32'h1234_5678, 0, 0, e_op, e_data, e_wr, e_rd);
      run_txn(2'(k), 7'h7F, 32'h1234_5678, 0, 0, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
      vectors++;
      if ({g_op, g_data, g_t} !== {2'd2, 32'd0, 1'b1} || g_wr != 0 || g_rd != 0) begin
        miscompares++;
        $display("FAIL unimpl_op%0d: got op=%0d data=%h wr=%0d rd=%0d timing=%b, expected op=2 data=0 no strobes",
                 k, g_op, g_data, g_wr, g_rd, g_t);
      end
    end
  endtask

  task automatic test_sticky_busy();
    pred(2'd2, 7'h10, 32'hAAAA_5555, 1, 0, e_op, e_data, e_wr, e_rd);
    run_txn(2'd2, 7'h10, 32'hAAAA_5555, 1, 0, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
    vectors++;
    if (g_op !== 2'd3 || g_data !== 32'd0 || g_wr != 0 || !g_t) begin
      miscompares++;
      $display("FAIL busy_write: got op=%0d data=%h wr=%0d, expected op=3 data=0 wr=0", g_op, g_data, g_wr);
    end
    pred(2'd1, 7'h10, 32'h0, 0, 0, e_op, e_data, e_wr, e_rd);
    run_txn(2'd1, 7'h10, 32'h0, 0, 0, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
    vectors++;
    if (g_op !== 2'd3 || g_data !== 32'd0 || g_rd != 0) begin
      miscompares++;
      $display("FAIL sticky_read: got op=%0d data=%h rd=%0d, expected op=3 data=0 rd=0", g_op, g_data, g_rd);
    end
    @(negedge clk); dmi_reset = 1'b1;
    @(negedge clk); dmi_reset = 1'b0;
    ref_sticky = 0;
    pred(2'd1, 7'h10, 32'h0, 0, 0, e_op, e_data, e_wr, e_rd);
    run_txn(2'd1, 7'h10, 32'h0, 0, 0, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
    vectors++;
    if (g_op !== 2'd0 || g_data !== e_data || g_rd != 1) begin
      miscompares++;
      $display("FAIL cleared_read: got op=%0d data=%h rd=%0d, expected op=0 data=%h rd=1", g_op, g_data, g_rd, e_data);
    end
    // busy error and dmi_reset in the same ACCESS cycle: the error survives
    pred(2'd2, 7'h11, 32'h0BAD_0BAD, 1, 0, e_op, e_data, e_wr, e_rd);
    run_txn(2'd2, 7'h11, 32'h0BAD_0BAD, 1, 0, 1, 0, g_op, g_data, g_wr, g_rd, g_t);
    pred(2'd1, 7'h11, 32'h0, 0, 0, e_op, e_data, e_wr, e_rd);
    run_txn(2'd1, 7'h11, 32'h0, 0, 0, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
    vectors++;
    if (g_op !== 2'd3 || g_rd != 0) begin
      miscompares++;
      $display("FAIL sticky_vs_dmi_reset: got op=%0d rd=%0d, expected op=3 rd=0", g_op, g_rd);
    end
    // dmi_reset together with acceptance clears before the access
    pred(2'd1, 7'h11, 32'h0, 0, 1, e_op, e_data, e_wr, e_rd);
    run_txn(2'd1, 7'h11, 32'h0, 0, 1, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
    vectors++;
    if (g_op !== 2'd0 || g_data !== e_data || g_rd != 1) begin
      miscompares++;
      $display("FAIL clear_at_accept: got op=%0d data=%h rd=%0d, expected op=0 data=%h rd=1", g_op, g_data, g_rd, e_data);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]    h_op;
    logic [DW-1:0] h_data;
    bit            ok;
    pred(2'd1, 7'h10, 32'h0, 0, 0, e_op, e_data, e_wr, e_rd);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_addr = 7'h10; req_data = 32'h0;
    @(negedge clk);
    req_op = 2'd2; req_addr = 7'h11; req_data = 32'hC0FF_EE01;
    ok = !req_ready;
    @(negedge clk);
    h_op = resp_op; h_data = resp_data;
    ok = ok && resp_valid && (h_op === e_op) && (h_data === e_data);
    repeat (5) begin
      @(negedge clk);
      ok = ok && resp_valid && !req_ready && (resp_op === h_op) && (resp_data === h_data);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    vectors++;
    if (!ok || resp_valid || !req_ready) begin
      miscompares++;
      $display("FAIL backpressure_hold: got op=%0d data=%h stable_ok=%b, expected op=%0d data=%h held", h_op, h_data, ok, e_op, e_data);
    end
    pred(2'd2, 7'h11, 32'hC0FF_EE01, 0, 0, e_op, e_data, e_wr, e_rd);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (req_ready || !reg_write || reg_addr !== 7'h11 || reg_wdata !== 32'hC0FF_EE01) begin
      miscompares++;
      $display("FAIL second_accept: got rdy=%b wr=%b addr=%h wd=%h, expected rdy=0 wr=1 addr=11 wd=c0ffee01",
               req_ready, reg_write, reg_addr, reg_wdata);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    vectors++;
    if (!resp_valid || resp_op !== e_op || resp_data !== e_data) begin
      miscompares++;
      $display("FAIL second_resp: got rv=%b op=%0d data=%h, expected rv=1 op=%0d data=%h", resp_valid, resp_op, resp_data, e_op, e_data);
    end
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_nop();
    for (int k = 0; k < 2; k++) begin
      logic [1:0] op;
      op = (k == 0) ? 2'd0 : 2'd3;
      pred(op, 7'h10, 32'hFFFF_FFFF, 0, 0, e_op, e_data, e_wr, e_rd);
      run_txn(op, 7'h10, 32'hFFFF_FFFF, 0, 0, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
      vectors++;
      if ({g_op, g_data, g_t} !== {2'd0, 32'd0, 1'b1} || g_wr != 0 || g_rd != 0) begin
        miscompares++;
        $display("FAIL nop_op%0d: got op=%0d data=%h wr=%0d rd=%0d timing=%b, expected op=0 data=0 no strobes",
                 op, g_op, g_data, g_wr, g_rd, g_t);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    pred(2'd2, 7'h12, 32'h1111_2222, 1, 0, e_op, e_data, e_wr, e_rd);
    run_txn(2'd2, 7'h12, 32'h1111_2222, 1, 0, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_addr = 7'h12; req_data = 32'h3333_4444;
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_sticky = 0;
    vectors++;
    if ({req_ready, resp_valid, reg_write, resp_op, resp_data} !== {1'b1, 1'b0, 1'b0, 2'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_access: got rdy=%b rv=%b wr=%b op=%0d data=%h, expected rdy=1 rv=0 wr=0 op=0 data=0",
               req_ready, resp_valid, reg_write, resp_op, resp_data);
    end
    pred(2'd1, 7'h12, 32'h0, 0, 0, e_op, e_data, e_wr, e_rd);
    run_txn(2'd1, 7'h12, 32'h0, 0, 0, 0, 0, g_op, g_data, g_wr, g_rd, g_t);
    vectors++;
    if (g_op !== 2'd0 || g_data !== e_data || g_rd != 1) begin
      miscompares++;
      $display("FAIL post_reset_read: got op=%0d data=%h rd=%0d, expected op=0 data=%h rd=1", g_op, g_data, g_rd, e_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            busy, ca, ci;
      op   = 2'($urandom_range(0, 3));
      addr = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 0) addr = 7'($urandom_range(0, 7));
      data = $urandom;
      busy = ($urandom_range(0, 7) == 0);
      ca   = ($urandom_range(0, 4) == 0);
      ci   = ($urandom_range(0, 9) == 0);
      pred(op, addr, data, busy, ca, e_op, e_data, e_wr, e_rd);
      run_txn(op, addr, data, busy, ca, ci, $urandom_range(0, 3), g_op, g_data, g_wr, g_rd, g_t);
      vectors++;
      if (g_op !== e_op || g_data !== e_data || g_wr != e_wr || g_rd != e_rd || !g_t ||
          (e_wr == 1 && (last_waddr !== addr || last_wdata !== data))) begin
        miscompares++;
        $display("FAIL random_%0d: op=%0d addr=%h busy=%b got op=%0d data=%h wr=%0d rd=%0d timing=%b, expected op=%0d data=%h wr=%0d rd=%0d",
                 n, op, addr, busy, g_op, g_data, g_wr, g_rd, g_t, e_op, e_data, e_wr, e_rd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      bank[i]    = $urandom;
      ref_mem[i] = bank[i];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_data = '0;
    resp_ready = 1'b0; dmi_reset = 1'b0; reg_busy = 1'b0; ref_sticky = 0;
    test_reset();
    test_write_read();
    test_unimplemented();
    test_sticky_busy();
    test_backpressure();
    test_nop();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
